// File: rtl/data_mem_arbiter_pkg.sv
// Purpose: shared FSM encoding, default widths and helpers for the data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package data_mem_arbiter_pkg;

  localparam int DEF_REG_WIDTH           = 12;
  localparam int DEF_CORE_COUNT          = 4;
  localparam int DEF_DATA_MEM_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_t;

  // Width of a core index; a single core still needs one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Purpose: bundles the per-core request/response lanes and the shared memory port.
// Latency: n/a (wiring only).
// Backpressure: requesters hold their lane stable until coreAck pulses.
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int REG_WIDTH           = DEF_REG_WIDTH,
  parameter int CORE_COUNT          = DEF_CORE_COUNT,
  parameter int DATA_MEM_ADDR_WIDTH = DEF_DATA_MEM_ADDR_WIDTH
);
  logic [CORE_COUNT-1:0]                     coreReq;
  logic [CORE_COUNT-1:0]                     coreWrEn;
  logic [DATA_MEM_ADDR_WIDTH*CORE_COUNT-1:0] coreAddr;
  logic [REG_WIDTH*CORE_COUNT-1:0]           coreWrData;
  logic [CORE_COUNT-1:0]                     coreAck;
  logic [REG_WIDTH*CORE_COUNT-1:0]           coreRdData;
  logic [CORE_COUNT-1:0]                     grant;
  logic [DATA_MEM_ADDR_WIDTH-1:0]            memAddr;
  logic                                      memWrEn;
  logic [REG_WIDTH-1:0]                      memDataIn;
  logic [REG_WIDTH-1:0]                      memDataOut;
  logic                                      busy;

  // Cores plus the memory: drive requests and read data, observe the arbiter.
  modport master (
    output coreReq, coreWrEn, coreAddr, coreWrData, memDataOut,
    input  coreAck, coreRdData, grant, memAddr, memWrEn, memDataIn, busy
  );

  // The arbiter itself.
  modport slave (
    input  coreReq, coreWrEn, coreAddr, coreWrData, memDataOut,
    output coreAck, coreRdData, grant, memAddr, memWrEn, memDataIn, busy
  );
endinterface

// File: rtl/data_mem_arbiter_rr_picker.sv
// Purpose: round-robin picker, first set request at or above ptr with wrap-around.
// Latency: combinational.
// Backpressure: none; valid is low when no request is set.
module rr_picker
  import data_mem_arbiter_pkg::*;
#(
  parameter int N     = DEF_CORE_COUNT,
  parameter int IDX_W = idxWidth(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W:0] cand;

  // Scan offsets from farthest to nearest so the nearest set bit is written last and wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(N)) cand = cand - (IDX_W + 1)'(N);
      if (req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Purpose: round-robin arbiter sharing one synchronous data memory among CORE_COUNT cores.
// Latency: 3 cycles per access (IDLE->ACCESS->RESP), ack in RESP, read data registered at end of RESP.
// Backpressure: a core holds req/addr/data until its one-cycle coreAck; ungranted cores wait.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int REG_WIDTH           = DEF_REG_WIDTH,
  parameter int CORE_COUNT          = DEF_CORE_COUNT,
  parameter int DATA_MEM_ADDR_WIDTH = DEF_DATA_MEM_ADDR_WIDTH
) (
  input logic               clk,
  input logic               rstN,
  data_mem_arbiter_if.slave bus
);

  localparam int IDX_W = idxWidth(CORE_COUNT);

  arbState_t                      state, stateNext;
  logic [IDX_W-1:0]               ptr;
  logic [IDX_W-1:0]               winnerIdx;
  logic                           latWrEn;
  logic [DATA_MEM_ADDR_WIDTH-1:0] latAddr;
  logic [REG_WIDTH-1:0]           latWrData;
  logic                           pickValid;
  logic [IDX_W-1:0]               pickIdx;

  logic [CORE_COUNT-1:0]           grantC;
  logic [CORE_COUNT-1:0]           ackC;
  logic [DATA_MEM_ADDR_WIDTH-1:0]  memAddrC;
  logic                            memWrEnC;
  logic [REG_WIDTH-1:0]            memDataInC;
  logic [REG_WIDTH*CORE_COUNT-1:0] rdDataQ;

  rr_picker #(.N(CORE_COUNT), .IDX_W(IDX_W)) uPicker (
    .req   (bus.coreReq),
    .ptr   (ptr),
    .valid (pickValid),
    .index (pickIdx)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state and memory/grant/ack outputs; everything is quiet in IDLE.
  always_comb begin
    stateNext  = state;
    grantC     = '0;
    ackC       = '0;
    memAddrC   = '0;
    memWrEnC   = 1'b0;
    memDataInC = '0;
    case (state)
      IDLE: begin
        if (pickValid) stateNext = ACCESS;
      end
      ACCESS: begin
        grantC[winnerIdx] = 1'b1;
        memAddrC          = latAddr;
        memWrEnC          = latWrEn;
        memDataInC        = latWrData;
        stateNext         = RESP;
      end
      RESP: begin
        grantC[winnerIdx] = 1'b1;
        ackC[winnerIdx]   = 1'b1;
        stateNext         = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture the winner's request at grant time and advance the round-robin pointer after it.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      ptr       <= '0;
      winnerIdx <= '0;
      latWrEn   <= 1'b0;
      latAddr   <= '0;
      latWrData <= '0;
    end else begin
      if (state == IDLE && pickValid) begin
        winnerIdx <= pickIdx;
        latWrEn   <= bus.coreWrEn[pickIdx];
        latAddr   <= bus.coreAddr[int'(pickIdx)*DATA_MEM_ADDR_WIDTH +: DATA_MEM_ADDR_WIDTH];
        latWrData <= bus.coreWrData[int'(pickIdx)*REG_WIDTH +: REG_WIDTH];
      end
      if (state == RESP) begin
        ptr <= (winnerIdx == IDX_W'(CORE_COUNT - 1)) ? '0 : winnerIdx + 1'b1;
      end
    end
  end

  // Per-core read data register, loaded from the RAM output as a read leaves RESP.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rdDataQ <= '0;
    end else if (state == RESP && !latWrEn) begin
      rdDataQ[int'(winnerIdx)*REG_WIDTH +: REG_WIDTH] <= bus.memDataOut;
    end
  end

  assign bus.grant      = grantC;
  assign bus.coreAck    = ackC;
  assign bus.memAddr    = memAddrC;
  assign bus.memWrEn    = memWrEnC;
  assign bus.memDataIn  = memDataInC;
  assign bus.coreRdData = rdDataQ;
  assign bus.busy       = (state != IDLE);

endmodule
